// File: rtl/apb_regfile_slave.sv
// APB completer exposing NUM_REGS memory-mapped registers with byte strobes,
// read-only slots, configurable wait states and pslverr on bad accesses.
module apb_regfile_slave #(
    parameter int unsigned         DATA_WIDTH  = 32,
    parameter int unsigned         ADDR_WIDTH  = 12,
    parameter int unsigned         NUM_REGS    = 16,
    parameter int unsigned         WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           pclk,
    input  logic                           preset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_value,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int unsigned NB   = DATA_WIDTH / 8;
    localparam int unsigned LSB  = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned WCW  = 4;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                  state_q;
    logic [WCW-1:0]          wcnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [NB-1:0]           strb_q;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    pready_q;
    logic                    pslverr_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic [ADDR_WIDTH-1:0]   acc_addr_c;
    logic                    acc_write_c;
    logic [ADDR_WIDTH-1:0]   idx_full_c;
    logic [IDXW-1:0]         idx_c;
    logic                    mis_c;
    logic                    oor_c;
    logic                    ro_c;
    logic                    err_c;
    logic [DATA_WIDTH-1:0]   rdata_c;
    logic [DATA_WIDTH-1:0]   wr_word_d;

    // Decode uses the live bus during setup (zero-wait response) and the
    // captured request once in ACCESS.
    always_comb begin
        acc_addr_c  = addr_q;
        acc_write_c = write_q;
        if (state_q == IDLE) begin
            acc_addr_c  = paddr;
            acc_write_c = pwrite;
        end
        idx_full_c = acc_addr_c >> LSB;
        mis_c      = (acc_addr_c & ADDR_WIDTH'(NB - 1)) != '0;
        oor_c      = idx_full_c >= ADDR_WIDTH'(NUM_REGS);
        idx_c      = IDXW'(idx_full_c);
        ro_c       = !oor_c && RO_MASK[idx_c];
        err_c      = mis_c || oor_c || (acc_write_c && ro_c);

        rdata_c = '0;
        if (!err_c && !acc_write_c) begin
            rdata_c = ro_c ? ro_value[32'(idx_c)*DATA_WIDTH +: DATA_WIDTH] : regs_q[idx_c];
        end

        wr_word_d = regs_q[idx_c];
        for (int unsigned b = 0; b < NB; b++) begin
            if (strb_q[b]) begin
                wr_word_d[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel && !penable) begin
                        state_q <= ACCESS;
                        addr_q  <= paddr;
                        write_q <= pwrite;
                        wdata_q <= pwdata;
                        strb_q  <= pstrb;
                        wcnt_q  <= WCW'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_c;
                            prdata_q  <= rdata_c;
                        end
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        // Requester abort: drop the transfer silently.
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else if (pready_q) begin
                        if (write_q && !err_c) begin
                            regs_q[idx_c] <= wr_word_d;
                        end
                        state_q   <= IDLE;
                        pready_q  <= 1'b0;
                        pslverr_q <= 1'b0;
                        prdata_q  <= '0;
                    end else begin
                        wcnt_q <= wcnt_q - WCW'(1);
                        if (wcnt_q == WCW'(1)) begin
                            pready_q  <= 1'b1;
                            pslverr_q <= err_c;
                            prdata_q  <= rdata_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_regq
        assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : regs_q[i];
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: one zero-wait and one 3-wait instance.
module tb_apb_regfile_slave;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 12;
    localparam int unsigned NR = 16;
    localparam logic [NR-1:0] ROM = 16'h0020;

    logic            pclk = 1'b0;
    logic            preset;
    logic            psel0, psel3, penable, pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [NR*DW-1:0] ro_value;
    logic [DW-1:0]   prdata0, prdata3;
    logic            pready0, pready3, pslverr0, pslverr3;
    logic [NR*DW-1:0] reg_q0, reg_q3;

    int checks   = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    apb_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                        .WAIT_STATES(0), .RO_MASK(ROM)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .ro_value(ro_value), .reg_q(reg_q0));

    apb_regfile_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                        .WAIT_STATES(3), .RO_MASK(ROM)) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .ro_value(ro_value), .reg_q(reg_q3));

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Setup + access phases; returns at the negedge where pready is first seen high.
    task automatic xfer(input bit use3, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                        output logic [DW-1:0] rd, output logic er, output int cyc);
        @(negedge pclk);
        psel0 = !use3; psel3 = use3; penable = 1'b0;
        pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge pclk);
        penable = 1'b1;
        cyc = 1;
        while (!(use3 ? pready3 : pready0) && cyc < 20) begin
            @(negedge pclk);
            cyc++;
        end
        rd = use3 ? prdata3 : prdata0;
        er = use3 ? pslverr3 : pslverr0;
    endtask

    task automatic idle();
        @(negedge pclk);
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    logic [DW-1:0]    rd;
    logic             er;
    int               cyc;
    logic [NR*DW-1:0] exp0, exp3;

    initial begin
        preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        ro_value = '0;
        ro_value[5*DW +: DW] = 32'hCAFEF00D;
        exp0 = '0; exp3 = '0;
        repeat (2) @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);

        check("rst_regq0", reg_q0, '0);
        check("rst_regq3", reg_q3, '0);
        check("rst_pready", NR*DW'({pready0, pready3}), '0);
        check("rst_pslverr", NR*DW'({pslverr0, pslverr3}), '0);
        check("rst_prdata", NR*DW'({prdata0, prdata3}), '0);

        xfer(1'b0, 1'b1, 12'h008, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        check("wr0_cycles", NR*DW'(cyc), NR*DW'(1));
        check("wr0_err", NR*DW'(er), '0);
        idle();
        exp0[2*DW +: DW] = 32'hDEADBEEF;
        check("wr0_regq", reg_q0, exp0);

        xfer(1'b0, 1'b0, 12'h008, '0, 4'h0, rd, er, cyc);
        check("rd0_cycles", NR*DW'(cyc), NR*DW'(1));
        check("rd0_data", NR*DW'(rd), NR*DW'(32'hDEADBEEF));
        idle();
        check("rd0_prdata_after", NR*DW'(prdata0), '0);

        xfer(1'b0, 1'b1, 12'h008, 32'h11223344, 4'h5, rd, er, cyc);
        check("strb_err", NR*DW'(er), '0);
        idle();
        exp0[2*DW +: DW] = 32'hDE22BE44;
        check("strb_regq", reg_q0, exp0);

        xfer(1'b0, 1'b1, 12'h00C, 32'h12345678, 4'h0, rd, er, cyc);
        check("nostrb_err", NR*DW'(er), '0);
        idle();
        check("nostrb_regq", reg_q0, exp0);

        xfer(1'b0, 1'b0, 12'h040, '0, 4'h0, rd, er, cyc);
        check("oor_err", NR*DW'(er), NR*DW'(1));
        check("oor_data", NR*DW'(rd), '0);
        idle();

        xfer(1'b0, 1'b1, 12'h002, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
        check("mis_err", NR*DW'(er), NR*DW'(1));
        idle();
        check("mis_regq", reg_q0, exp0);

        xfer(1'b0, 1'b1, 12'h014, 32'h12345678, 4'hF, rd, er, cyc);
        check("ro_wr_err", NR*DW'(er), NR*DW'(1));
        idle();
        check("ro_wr_regq", reg_q0, exp0);

        xfer(1'b0, 1'b0, 12'h014, '0, 4'h0, rd, er, cyc);
        check("ro_rd_err", NR*DW'(er), '0);
        check("ro_rd_data", NR*DW'(rd), NR*DW'(32'hCAFEF00D));
        idle();

        xfer(1'b1, 1'b1, 12'h004, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
        check("ws_cycles", NR*DW'(cyc), NR*DW'(4));
        check("ws_not_yet", reg_q3, exp3);
        idle();
        exp3[1*DW +: DW] = 32'hA5A5A5A5;
        check("ws_commit", reg_q3, exp3);

        xfer(1'b1, 1'b0, 12'h004, '0, 4'h0, rd, er, cyc);
        check("ws_rd_cycles", NR*DW'(cyc), NR*DW'(4));
        check("ws_rd_data", NR*DW'(rd), NR*DW'(32'hA5A5A5A5));
        idle();

        // Abort after one access cycle.
        @(negedge pclk);
        psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h00C;
        pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        @(negedge pclk);
        psel3 = 1'b0; penable = 1'b0;
        repeat (5) @(negedge pclk);
        check("abort_pready", NR*DW'(pready3), '0);
        check("abort_regq", reg_q3, exp3);

        xfer(1'b1, 1'b0, 12'h00C, '0, 4'h0, rd, er, cyc);
        check("post_abort_cycles", NR*DW'(cyc), NR*DW'(4));
        check("post_abort_data", NR*DW'(rd), '0);
        idle();

        // Reset while the completion edge is pending.
        xfer(1'b1, 1'b1, 12'h000, 32'h77777777, 4'hF, rd, er, cyc);
        check("mid_rst_cycles", NR*DW'(cyc), NR*DW'(4));
        preset = 1'b1;
        @(negedge pclk);
        check("mid_rst_regq3", reg_q3, '0);
        check("mid_rst_regq0", reg_q0, '0);
        check("mid_rst_outs", NR*DW'({pready3, pslverr3, prdata3}), '0);
        preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
        repeat (2) @(negedge pclk);
        check("mid_rst_nowrite", reg_q3, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
